// File: rtl/nabp_filter_sequencer_pkg.sv
// Shared sizing constants and FSM encoding for the NABP projection filter sequencer.
package nabp_filter_sequencer_pkg;

  localparam int unsigned kDataLength         = 16;
  localparam int unsigned kFilteredDataLength = 32;
  localparam int unsigned kFilterDelay        = 8;
  localparam int unsigned kLineLength         = 256;
  localparam int unsigned kLineCntWidth       = 10;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StStream = 3'd2,
    StDrain  = 3'd3,
    StDone   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/nabp_valid_tag_pipe.sv
// Enable-gated valid tag shift register that tracks the filter's group delay.
module nabp_valid_tag_pipe #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_head,
  output logic o_tail,
  output logic o_any
);

  logic [DEPTH-1:0] r_tags;
  logic [DEPTH-1:0] w_shift;

  generate
    if (DEPTH == 1) begin : g_single
      assign w_shift = i_head;
    end else begin : g_multi
      assign w_shift = {r_tags[DEPTH-2:0], i_head};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tags <= '0;
    end else if (i_clear) begin
      r_tags <= '0;
    end else if (i_enable) begin
      r_tags <= w_shift;
    end
  end

  assign o_tail = r_tags[DEPTH-1];
  assign o_any  = |r_tags;

endmodule

// File: rtl/nabp_filter_sequencer.sv
// Sequences the projection filter line by line, aligning valid/last framing with the
// filter's group delay and stalling the filter under downstream backpressure.
module nabp_filter_sequencer
  import nabp_filter_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W       = kDataLength,
  parameter int unsigned FDATA_W      = kFilteredDataLength,
  parameter int unsigned FILTER_DELAY = kFilterDelay,
  parameter int unsigned LINE_LEN     = kLineLength,
  parameter int unsigned LINE_CNT_W   = kLineCntWidth
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LINE_CNT_W-1:0] num_lines,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  filt_enable,
  output logic                  filt_clear,
  output logic [DATA_W-1:0]     filt_val_in,
  input  logic [FDATA_W-1:0]    filt_val_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FDATA_W-1:0]    out_data,
  output logic                  out_last,
  output logic [LINE_CNT_W-1:0] out_line_idx
);

  localparam int unsigned InCntW  = $clog2(LINE_LEN + 1);
  localparam int unsigned OutCntW = $clog2(LINE_LEN);
  localparam logic [InCntW-1:0]  InFull  = InCntW'(LINE_LEN);
  localparam logic [InCntW-1:0]  InLast  = InCntW'(LINE_LEN - 1);
  localparam logic [OutCntW-1:0] OutLast = OutCntW'(LINE_LEN - 1);

  seq_state_e r_state, w_state_d;

  logic [LINE_CNT_W-1:0] r_num_lines;
  logic [LINE_CNT_W-1:0] r_line_idx;
  logic [LINE_CNT_W-1:0] w_line_nxt;
  logic [InCntW-1:0]     r_in_cnt;
  logic [OutCntW-1:0]    r_out_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic w_active;
  logic w_stream;
  logic w_clear;
  logic w_tail;
  logic w_any;
  logic w_out_valid;
  logic w_stall;
  logic w_enable;
  logic w_in_ready;
  logic w_accept;
  logic w_out_hs;
  logic w_start_ok;

  assign w_stream    = (r_state == StStream);
  assign w_active    = w_stream || (r_state == StDrain);
  assign w_clear     = (r_state == StClear);
  assign w_out_valid = w_active & w_tail;
  assign w_stall     = w_out_valid & ~out_ready;
  assign w_enable    = w_active & ~w_stall;
  assign w_in_ready  = w_stream & ~w_stall & (r_in_cnt < InFull);
  assign w_accept    = in_valid & w_in_ready;
  assign w_out_hs    = w_out_valid & out_ready;
  assign w_start_ok  = (r_state == StIdle) & start;
  assign w_line_nxt  = r_line_idx + 1'b1;

  nabp_valid_tag_pipe #(
    .DEPTH (FILTER_DELAY)
  ) u_tag_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .i_head   (w_accept),
    .o_tail   (w_tail),
    .o_any    (w_any)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = (num_lines == '0) ? StDone : StClear;
        end
      end
      StClear: w_state_d = StStream;
      StStream: begin
        if (w_accept && (r_in_cnt == InLast)) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        // An empty tag vector means every in-flight sample has been handed off.
        if (!w_any) begin
          w_state_d = (w_line_nxt == r_num_lines) ? StDone : StClear;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_num_lines <= '0;
      r_line_idx  <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= (r_state == StDone);

      if (w_start_ok) begin
        r_num_lines <= num_lines;
        r_line_idx  <= '0;
        r_busy      <= 1'b1;
      end else if (r_state == StDone) begin
        r_busy <= 1'b0;
      end

      if ((r_state == StDrain) && !w_any) begin
        r_line_idx <= w_line_nxt;
      end

      if (w_clear) begin
        r_in_cnt <= '0;
      end else if (w_accept) begin
        r_in_cnt <= r_in_cnt + 1'b1;
      end

      if (w_clear) begin
        r_out_cnt <= '0;
      end else if (w_out_hs) begin
        r_out_cnt <= r_out_cnt + 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign in_ready     = w_in_ready;
  assign filt_enable  = w_enable;
  assign filt_clear   = w_clear;
  assign filt_val_in  = w_accept ? in_data : '0;
  assign out_valid    = w_out_valid;
  // Filter output is undefined after reset, so it is masked until a tagged sample emerges.
  assign out_data     = w_out_valid ? filt_val_out : '0;
  assign out_last     = w_out_valid & (r_out_cnt == OutLast);
  assign out_line_idx = r_line_idx;

endmodule

// File: tb/tb_nabp_filter_sequencer.sv
// Scoreboard bench for nabp_filter_sequencer with a behavioural delay-line filter model.
module tb_nabp_filter_sequencer;

  localparam int unsigned DW  = 16;
  localparam int unsigned FW  = 32;
  localparam int unsigned FD  = 3;
  localparam int unsigned LL  = 4;
  localparam int unsigned LCW = 10;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [LCW-1:0] num_lines;
  logic           busy, done;
  logic           in_valid, in_ready;
  logic [DW-1:0]  in_data;
  logic           filt_enable, filt_clear;
  logic [DW-1:0]  filt_val_in;
  logic [FW-1:0]  filt_val_out;
  logic           out_valid, out_ready, out_last;
  logic [FW-1:0]  out_data;
  logic [LCW-1:0] out_line_idx;

  always #5 clk = ~clk;

  nabp_filter_sequencer #(
    .DATA_W       (DW),
    .FDATA_W      (FW),
    .FILTER_DELAY (FD),
    .LINE_LEN     (LL),
    .LINE_CNT_W   (LCW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .num_lines    (num_lines),
    .busy         (busy),
    .done         (done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .filt_enable  (filt_enable),
    .filt_clear   (filt_clear),
    .filt_val_in  (filt_val_in),
    .filt_val_out (filt_val_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_line_idx (out_line_idx)
  );

  function automatic logic [FW-1:0] fmodel(input logic [DW-1:0] x);
    return {16'h0, x} * 32'd5 + 32'd3;
  endfunction

  // External filter: a pure FD-stage delay of fmodel(sample); not reset by reset_n.
  logic [FW-1:0] fd_q [FD] = '{default: '0};
  always @(posedge clk) begin
    if (filt_clear) begin
      for (int i = 0; i < FD; i++) fd_q[i] <= '0;
    end else if (filt_enable) begin
      fd_q[0] <= fmodel(filt_val_in);
      for (int i = 1; i < FD; i++) fd_q[i] <= fd_q[i-1];
    end
  end
  assign filt_val_out = fd_q[FD-1];

  typedef struct {
    logic [FW-1:0]  data;
    logic           last;
    logic [LCW-1:0] line;
    int             adv;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int run_clears, done_cnt, last_cnt, out_seen, stall_cnt;
  int mdl_cnt = 0;
  int adv_cnt = 0;
  logic          in_stall = 1'b0;
  logic [FW-1:0] stall_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      exp_t e;
      if (filt_clear) begin
        run_clears++;
        mdl_cnt = 0;
      end
      if (in_valid && in_ready) begin
        check_val("filt_val_in", 64'(filt_val_in), 64'(in_data));
        e.data = fmodel(in_data);
        e.last = (mdl_cnt == LL - 1);
        e.line = LCW'(run_clears - 1);
        e.adv  = adv_cnt;
        sb_q.push_back(e);
        mdl_cnt++;
      end
      if (out_valid) check_val("valid_state", 64'(busy & ~filt_clear), 64'd1);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("extra_out", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("out_data", 64'(out_data), 64'(e.data));
          check_val("out_last", 64'(out_last), 64'(e.last));
          check_val("out_line_idx", 64'(out_line_idx), 64'(e.line));
          check_val("latency_adv", 64'(adv_cnt), 64'(e.adv + FD));
        end
        out_seen++;
        if (out_last) last_cnt++;
      end
      if (out_valid && !out_ready) begin
        stall_cnt++;
        check_val("stall_enable", 64'(filt_enable), 64'd0);
        check_val("stall_in_ready", 64'(in_ready), 64'd0);
        if (in_stall) check_val("stall_hold", 64'(out_data), 64'(stall_data));
        stall_data = out_data;
        in_stall   = 1'b1;
      end else begin
        in_stall = 1'b0;
      end
      if (done) done_cnt++;
      if (filt_enable) adv_cnt++;
    end
  end

  task automatic begin_run();
    run_clears = 0;
    done_cnt   = 0;
    last_cnt   = 0;
    out_seen   = 0;
    stall_cnt  = 0;
  endtask

  // Entered and left at posedge+1; the accepted start is checked for its CLEAR cycle.
  task automatic do_start(input int n);
    start     = 1'b1;
    num_lines = LCW'(n);
    @(negedge clk);
    @(posedge clk); #1;
    start     = 1'b0;
    num_lines = LCW'(7);
    @(negedge clk);
    check_val("clear_after_start", 64'(filt_clear), 64'(n != 0));
    check_val("busy_after_start", 64'(busy), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit hs = 0;
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      hs = in_ready;
      guard++;
    end while (!hs && guard < 200);
    if (!hs) check_val("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check_val("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic end_run(input int lines);
    repeat (3) @(posedge clk);
    #1;
    check_val("clear_count", 64'(run_clears), 64'(lines));
    check_val("done_count", 64'(done_cnt), 64'd1);
    check_val("last_count", 64'(last_cnt), 64'(lines));
    check_val("out_count", 64'(out_seen), 64'(lines * LL));
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    check_val("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_ctl"}, 64'({busy, done, in_ready, filt_enable, filt_clear, out_valid,
                                  out_last, out_line_idx, filt_val_in}), 64'd0);
    check_val({tag, "_data"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    num_lines = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single line, back-to-back
    begin_run();
    do_start(1);
    for (int i = 1; i <= 4; i++) send(DW'(i));
    wait_done();
    end_run(1);

    // Bubbles between samples
    begin_run();
    do_start(1);
    for (int i = 0; i < 4; i++) begin
      send(DW'($urandom_range(0, 65535)));
      @(posedge clk); #1;
    end
    wait_done();
    end_run(1);

    // Backpressure mid-line
    begin_run();
    do_start(2);
    fork
      for (int i = 0; i < 2 * LL; i++) send(DW'($urandom_range(0, 65535)));
      begin
        int g = 0;
        do begin
          @(posedge clk); #2;
          g++;
        end while (!(out_valid && out_seen >= 1) && g < 200);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    wait_done();
    end_run(2);
    check_val("stall_cycles", 64'(stall_cnt), 64'd5);

    // Multi-line with an ignored start while busy
    begin_run();
    do_start(3);
    fork
      for (int i = 0; i < 3 * LL; i++) send(DW'($urandom_range(0, 65535)));
      begin
        repeat (6) @(posedge clk);
        #1;
        start     = 1'b1;
        num_lines = LCW'(1);
        @(posedge clk); #1;
        start     = 1'b0;
      end
    join
    wait_done();
    end_run(3);

    // Zero-length run
    begin_run();
    do_start(0);
    @(negedge clk);
    check_val("zero_done", 64'({done, busy}), 64'b10);
    repeat (3) @(posedge clk);
    #1;
    check_val("zero_clears", 64'(run_clears), 64'd0);
    check_val("zero_done_count", 64'(done_cnt), 64'd1);

    // Reset in the middle of STREAM, then a clean run
    begin_run();
    do_start(2);
    for (int i = 0; i < 3; i++) send(DW'(16'hA000 + i));
    reset_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    sb_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    begin_run();
    do_start(1);
    for (int i = 0; i < 4; i++) send(DW'(16'h0B00 + i));
    wait_done();
    end_run(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
